// File: rtl/add_share_arbiter.sv
// Round-robin arbiter that shares one WIDTH-bit adder between NREQ requesters.
// Each result lands in a one-entry output slot with valid/ready backpressure.
module add_share_arbiter #(
  parameter  int WIDTH = 32,
  parameter  int NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic [NREQ-1:0]         req_ready,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [IDW-1:0]          resp_id,
  output logic [WIDTH-1:0]        resp_sum,
  output logic                    resp_cout
);

  // Handshake rules:
  //  - A request i is consumed on a rising edge where req_valid[i] & req_ready[i].
  //  - A result is consumed on a rising edge where resp_valid & resp_ready.
  //  - req_ready is a combinational function of req_valid, resp_ready and the
  //    slot state, so requesters must not make req_valid depend on req_ready.
  //  - While resp_valid & !resp_ready the slot contents hold stable.

  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW:0]     scan_idx;
  logic             found;
  logic             accept;
  logic             grant;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH:0]   sum_full;
  logic [IDW-1:0]   ptr_next;

  assign accept = !resp_valid || resp_ready;

  // Scan from ptr upwards with wrap; the extra index bit keeps the wrap exact
  // when NREQ is not a power of two.
  always_comb begin
    found    = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = {1'b0, ptr} + (IDW+1)'(k);
      if (scan_idx >= (IDW+1)'(NREQ)) begin
        scan_idx = scan_idx - (IDW+1)'(NREQ);
      end
      if (!found && req_valid[scan_idx[IDW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = scan_idx[IDW-1:0];
      end
    end
  end

  assign grant     = rst_n && accept && found;
  assign req_ready = grant ? (NREQ'(1) << gnt_idx) : '0;

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        a_sel = req_a[i*WIDTH +: WIDTH];
        b_sel = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign sum_full = {1'b0, a_sel} + {1'b0, b_sel};
  assign ptr_next = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_sum   <= '0;
      resp_cout  <= 1'b0;
    end else if (grant) begin
      // A grant may coincide with a drain; the new result simply replaces it.
      ptr        <= ptr_next;
      resp_valid <= 1'b1;
      resp_id    <= gnt_idx;
      resp_sum   <= sum_full[WIDTH-1:0];
      resp_cout  <= sum_full[WIDTH];
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_add_share_arbiter.sv
// Self-checking bench for add_share_arbiter: directed cases from the test plan
// plus randomized traffic checked against a queue-based reference model.
module tb_add_share_arbiter;

  localparam int WIDTH = 32;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int EW    = IDW + 1 + WIDTH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT (NREQ=4) ----------------
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ*WIDTH-1:0] req_a = '0;
  logic [NREQ*WIDTH-1:0] req_b = '0;
  logic [NREQ-1:0]       req_ready;
  logic                  resp_valid;
  logic                  resp_ready = 1'b0;
  logic [IDW-1:0]        resp_id;
  logic [WIDTH-1:0]      resp_sum;
  logic                  resp_cout;

  add_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_sum(resp_sum), .resp_cout(resp_cout)
  );

  // ---------------- DUT (NREQ=3) ----------------
  logic [2:0]         r3_valid = '0;
  logic [3*WIDTH-1:0] r3_a = '0;
  logic [3*WIDTH-1:0] r3_b = '0;
  logic [2:0]         r3_ready;
  logic               r3_resp_valid;
  logic               r3_resp_ready = 1'b1;
  logic [1:0]         r3_id;
  logic [WIDTH-1:0]   r3_sum;
  logic               r3_cout;

  add_share_arbiter #(.WIDTH(WIDTH), .NREQ(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(r3_valid), .req_a(r3_a), .req_b(r3_b), .req_ready(r3_ready),
    .resp_valid(r3_resp_valid), .resp_ready(r3_resp_ready),
    .resp_id(r3_id), .resp_sum(r3_sum), .resp_cout(r3_cout)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];   // expected slot contents {id, cout, sum}
  int mptr = 0;              // model round-robin pointer

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_grant(input int p, input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_ops(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  // One clock of traffic: drive, check grant, advance the model, check slot.
  task automatic drive_cycle(input logic [NREQ-1:0] v, input logic rr);
    int g;
    bit acc;
    logic [NREQ-1:0] exp_rdy;
    logic [WIDTH:0] s;
    logic [EW-1:0] e;
    @(negedge clk);
    req_valid  = v;
    resp_ready = rr;
    #1;
    g       = model_grant(mptr, v);
    acc     = (exp_q.size() == 0) || rr;
    exp_rdy = (acc && g >= 0) ? NREQ'(1 << g) : '0;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    @(posedge clk);
    if (exp_q.size() != 0 && rr) void'(exp_q.pop_front());
    if (acc && g >= 0) begin
      s = {1'b0, req_a[g*WIDTH +: WIDTH]} + {1'b0, req_b[g*WIDTH +: WIDTH]};
      exp_q.push_back({IDW'(g), s});
      mptr = (g + 1) % NREQ;
    end
    #1;
    check("resp_valid", 64'(resp_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      e = exp_q[0];
      check("resp_id",   64'(resp_id),   64'(e[EW-1 -: IDW]));
      check("resp_cout", 64'(resp_cout), 64'(e[WIDTH]));
      check("resp_sum",  64'(resp_sum),  64'(e[WIDTH-1:0]));
    end
  endtask

  function automatic logic [WIDTH-1:0] rand_op();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] exp3_ready;
    logic [WIDTH-1:0] exp3_sum;
    int tbl3[7];
    tbl3 = '{0, 1, 2, 0, 1, 2, 2};

    // Reset state, with requests already raised
    req_valid = '1;
    r3_valid  = '1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready",  64'(req_ready),  64'(0));
    check("rst_resp_valid", 64'(resp_valid), 64'(0));
    check("rst_resp_id",    64'(resp_id),    64'(0));
    check("rst_resp_sum",   64'(resp_sum),   64'(0));
    check("rst_resp_cout",  64'(resp_cout),  64'(0));
    check("rst_r3_ready",   64'(r3_ready),   64'(0));
    req_valid = '0;
    r3_valid  = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // NREQ=3 build: 111 held gives 0,1,2,0,1,2; then requester 2 alone at ptr=0
    for (int i = 0; i < 3; i++) begin
      r3_a[i*WIDTH +: WIDTH] = WIDTH'(i * 100 + 1);
      r3_b[i*WIDTH +: WIDTH] = WIDTH'(i + 7);
    end
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      r3_valid = (k < 6) ? 3'b111 : 3'b100;
      #1;
      exp3_ready = 3'(1 << tbl3[k]);
      check("r3_grant", 64'(r3_ready), 64'(exp3_ready));
      @(posedge clk);
      #1;
      exp3_sum = WIDTH'(tbl3[k] * 100 + 1 + tbl3[k] + 7);
      check("r3_valid", 64'(r3_resp_valid), 64'(1));
      check("r3_id",    64'(r3_id),         64'(tbl3[k]));
      check("r3_sum",   64'(r3_sum),        64'(exp3_sum));
    end
    @(negedge clk);
    r3_valid = '0;

    // Round-robin with all four requesting
    for (int i = 0; i < NREQ; i++) set_ops(i, WIDTH'(32'h1000 * (i + 1)), WIDTH'(i * 3 + 1));
    for (int k = 0; k < 8; k++) begin
      drive_cycle(4'b1111, 1'b1);
      check("rr_order", 64'(resp_id), 64'(k % 4));
      check("rr_sum",   64'(resp_sum), 64'(32'h1000 * (k % 4 + 1) + (k % 4) * 3 + 1));
    end

    // Backpressure: id 2 pending, 1011 requesting while stalled
    drive_cycle(4'b0100, 1'b1);
    check("bp_id2", 64'(resp_id), 64'(2));
    for (int k = 0; k < 3; k++) begin
      drive_cycle(4'b1011, 1'b0);
      check("bp_stall_id",  64'(resp_id),  64'(2));
      check("bp_stall_sum", 64'(resp_sum), 64'(32'h3000 + 7));
    end
    drive_cycle(4'b1011, 1'b1);
    check("bp_next_id3", 64'(resp_id), 64'(3));

    // Basic add and carry-out
    set_ops(0, 32'd5, 32'd7);
    drive_cycle(4'b0001, 1'b1);
    check("add_sum",  64'(resp_sum),  64'(12));
    check("add_cout", 64'(resp_cout), 64'(0));
    set_ops(0, 32'hFFFF_FFFF, 32'h0000_0002);
    drive_cycle(4'b0001, 1'b1);
    check("carry_sum",  64'(resp_sum),  64'(1));
    check("carry_cout", 64'(resp_cout), 64'(1));

    // Drain without refill
    drive_cycle(4'b0000, 1'b1);
    check("drain_valid", 64'(resp_valid), 64'(0));

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) set_ops(i, rand_op(), rand_op());
      drive_cycle(NREQ'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
    end

    // Asynchronous reset mid-cycle while a result is held
    set_ops(1, 32'd10, 32'd20);
    drive_cycle(4'b0010, 1'b0);
    #2;
    req_valid = 4'b1111;
    resp_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check("arst_resp_valid", 64'(resp_valid), 64'(0));
    check("arst_req_ready",  64'(req_ready),  64'(0));
    exp_q.delete();
    mptr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    set_ops(2, 32'd40, 32'd2);
    drive_cycle(4'b0100, 1'b1);
    check("arst_after_id",  64'(resp_id),  64'(2));
    check("arst_after_sum", 64'(resp_sum), 64'(42));

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
